// File: rtl/bf16_result_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bf16_result_tx                                                |
// | Purpose  : UART (8N1) transmitter for 16-bit bfloat16 result words.      |
// |            Defining BF16_TX_HEX_EN sends 4 ASCII hex digits + CR LF.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bf16_result_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] result_in,
  input  logic        result_valid,
  output logic        result_ready,
  output logic        tx,
  output logic        busy
);

  // Counter is kept at least 1 bit wide so CLKS_PER_BIT=1 still elaborates.
  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef BF16_TX_HEX_EN
  localparam int c_NBYTES = 6;
`else
  localparam int c_NBYTES = 2;
`endif
  localparam int c_BYTE_W = $clog2(c_NBYTES);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BYTE_W-1:0] c_BYTE_LAST = c_BYTE_W'(c_NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_BAUD_W-1:0]   r_baud;
  logic [c_BAUD_W-1:0]   w_baud_next;
  logic [2:0]            r_bit;
  logic [2:0]            w_bit_next;
  logic [2:0]            w_bit_inc;
  logic [c_BYTE_W-1:0]   r_byte;
  logic [c_BYTE_W-1:0]   w_byte_next;
  logic [15:0]           r_hold;
  logic                  r_tx;
  logic                  w_tx_next;
  logic                  w_accept;
  logic                  w_baud_last;
  logic [7:0]            w_cur_byte;

  assign busy         = (r_state != S_IDLE);
  assign result_ready = !busy;
  assign tx           = r_tx;
  assign w_accept     = result_valid && (r_state == S_IDLE);
  assign w_baud_last  = (r_baud == c_BAUD_LAST);
  assign w_bit_inc    = r_bit + 3'd1;

`ifdef BF16_TX_HEX_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  always_comb begin
    w_cur_byte = 8'h0A;
    case (r_byte)
      3'd0:    w_cur_byte = hex_ascii(r_hold[15:12]);
      3'd1:    w_cur_byte = hex_ascii(r_hold[11:8]);
      3'd2:    w_cur_byte = hex_ascii(r_hold[7:4]);
      3'd3:    w_cur_byte = hex_ascii(r_hold[3:0]);
      3'd4:    w_cur_byte = 8'h0D;
      default: w_cur_byte = 8'h0A;
    endcase
  end
`else
  always_comb begin
    w_cur_byte = (r_byte == '0) ? r_hold[15:8] : r_hold[7:0];
  end
`endif

  // Next tx level is decided alongside the state so tx comes straight from a flop.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_byte_next  = r_byte;
    w_tx_next    = r_tx;
    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        w_bit_next  = 3'd0;
        w_byte_next = '0;
        w_tx_next   = 1'b1;
        if (w_accept) begin
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_bit_next   = 3'd0;
          w_state_next = S_DATA;
          w_tx_next    = w_cur_byte[0];
        end else begin
          w_baud_next = r_baud + c_BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_next = w_bit_inc;
            w_tx_next  = w_cur_byte[w_bit_inc];
          end
        end else begin
          w_baud_next = r_baud + c_BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (r_byte == c_BYTE_LAST) begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end else begin
            w_byte_next  = r_byte + c_BYTE_W'(1);
            w_state_next = S_START;
            w_tx_next    = 1'b0;
          end
        end else begin
          w_baud_next = r_baud + c_BAUD_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_byte  <= '0;
      r_hold  <= 16'h0000;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_byte  <= w_byte_next;
      r_tx    <= w_tx_next;
      if (w_accept) begin
        r_hold <= result_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bf16_result_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bf16_result_tx                                             |
// | Purpose  : Self-checking bench for bf16_result_tx (CLKS_PER_BIT 4 and 1).|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bf16_result_tx;

`ifdef BF16_TX_HEX_EN
  localparam int c_NB = 6;
`else
  localparam int c_NB = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in4, in1;
  logic        v4, v1;
  logic        rdy4, tx4, busy4;
  logic        rdy1, tx1, busy1;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  bf16_result_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .result_in(in4), .result_valid(v4),
    .result_ready(rdy4), .tx(tx4), .busy(busy4)
  );

  bf16_result_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .result_in(in1), .result_valid(v1),
    .result_ready(rdy1), .tx(tx1), .busy(busy1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte k of the transfer for word w, straight from the framing rules.
  function automatic logic [7:0] model_byte(input logic [15:0] w, input int k);
`ifdef BF16_TX_HEX_EN
    string s;
    s = $sformatf("%04X", w);
    if (k == 4) return 8'h0D;
    if (k == 5) return 8'h0A;
    return s[k];
`else
    return (k == 0) ? w[15:8] : w[7:0];
`endif
  endfunction

  // Expected line level c cycles after the accept edge.
  function automatic logic model_line(input logic [15:0] w, input int cpb, input int c);
    int   bitpos, k;
    logic [7:0] b;
    bitpos = c / cpb;
    k      = bitpos % 10;
    b      = model_byte(w, bitpos / 10);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic logic get_tx(input int sel);   return (sel != 0) ? tx1   : tx4;   endfunction
  function automatic logic get_busy(input int sel); return (sel != 0) ? busy1 : busy4; endfunction
  function automatic logic get_rdy(input int sel);  return (sel != 0) ? rdy1  : rdy4;  endfunction

  task automatic drive(input int sel, input logic v, input logic [15:0] w);
    if (sel != 0) begin v1 = v; in1 = w; end
    else          begin v4 = v; in4 = w; end
  endtask

  task automatic check_idle(input int sel, input string tag);
    check_val({tag, "_tx"},   {31'd0, get_tx(sel)},   32'd1);
    check_val({tag, "_busy"}, {31'd0, get_busy(sel)}, 32'd0);
    check_val({tag, "_rdy"},  {31'd0, get_rdy(sel)},  32'd1);
  endtask

  // Called #1 after an edge; one-cycle valid pulse accepted on the next edge.
  task automatic send(input int sel, input logic [15:0] w);
    drive(sel, 1'b1, w);
    check_val("rdy_pre_accept", {31'd0, get_rdy(sel)}, 32'd1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 16'h0000);
  endtask

  // Checks the line cycle by cycle from the accept edge; limit<0 means whole transfer.
  task automatic check_frame(input int sel, input logic [15:0] w, input int cpb, input int limit);
    int total, n;
    total = c_NB * 10 * cpb;
    n     = (limit < 0 || limit > total) ? total : limit;
    for (int c = 0; c < n; c++) begin
      check_val($sformatf("tx_%04h_c%0d", w, c), {31'd0, get_tx(sel)}, {31'd0, model_line(w, cpb, c)});
      check_val($sformatf("busy_%04h_c%0d", w, c), {31'd0, get_busy(sel)}, 32'd1);
      check_val($sformatf("rdy_%04h_c%0d", w, c), {31'd0, get_rdy(sel)}, 32'd0);
      @(posedge clk); #1;
    end
    if (n == total) check_idle(sel, $sformatf("end_%04h", w));
  endtask

  initial begin
    rst = 1'b1;
    v4 = 1'b0; v1 = 1'b0; in4 = 16'h0000; in1 = 16'h0000;
    repeat (3) begin
      @(posedge clk); #1;
      check_idle(0, "rst4");
      check_idle(1, "rst1");
    end
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check_idle(0, "idle4");
      check_idle(1, "idle1");
    end

    // Single raw word
    send(0, 16'h3F80);
    check_frame(0, 16'h3F80, 4, -1);

    // Back-pressure: second word held valid for the whole first transfer
    send(0, 16'h3F80);
    drive(0, 1'b1, 16'hC000);
    check_frame(0, 16'h3F80, 4, -1);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0000);
    check_frame(0, 16'hC000, 4, -1);

    // Reset during bit 3 of the second byte (cycles 56..59)
    send(0, 16'h3F80);
    check_frame(0, 16'h3F80, 4, 58);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_tx",   {31'd0, tx4},   32'd1);
    check_val("midrst_busy", {31'd0, busy4}, 32'd0);
    rst = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      check_idle(0, "post_rst");
    end
    send(0, 16'h4049);
    check_frame(0, 16'h4049, 4, -1);

    // One clock per bit
    send(1, 16'hFFFF);
    check_frame(1, 16'hFFFF, 1, -1);

    send(0, 16'hBF80);
    check_frame(0, 16'hBF80, 4, -1);

    // Random words on both instances with random idle gaps
    repeat (24) begin
      int          sel;
      logic [15:0] w;
      sel = int'($urandom_range(0, 1));
      w   = 16'($urandom);
      send(sel, w);
      check_frame(sel, w, (sel != 0) ? 1 : 4, -1);
      repeat (int'($urandom_range(0, 3))) begin
        @(posedge clk); #1;
        check_idle(sel, "gap");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
